// File: rtl/dll_tx_packet_mux_ff_if.sv
// Link-side TX bundle for the DLL packet mux: DLC state, DLLP/TLP sources and the
// registered 1196-bit stream toward the link. "slave" is the mux, "master" its peers.
interface dll_tx_packet_mux_ff_if;
  logic [1:0]    dlc_state_i;
  logic [47:0]   dllp_i;
  logic          dllp_valid_i;
  logic          dllp_ready_o;
  logic [1195:0] tlp_i;
  logic          tlp_valid_i;
  logic          tlp_ready_o;
  logic [1195:0] tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic          tlp_err_o;

  modport slave (
    input  dlc_state_i,
    input  dllp_i,
    input  dllp_valid_i,
    output dllp_ready_o,
    input  tlp_i,
    input  tlp_valid_i,
    output tlp_ready_o,
    output tx_data_o,
    output tx_valid_o,
    input  tx_ready_i,
    output tlp_err_o
  );

  modport master (
    output dlc_state_i,
    output dllp_i,
    output dllp_valid_i,
    input  dllp_ready_o,
    output tlp_i,
    output tlp_valid_i,
    input  tlp_ready_o,
    input  tx_data_o,
    input  tx_valid_o,
    output tx_ready_i,
    input  tlp_err_o
  );
endinterface

// File: rtl/dll_tx_packet_mux_ff.sv
// DLL TX packet mux: merges DLLPs and TLPs onto the link stream with DLC-state gating,
// DLLP priority bounded by an anti-starvation limit, and one registered output stage.

module dll_tx_packet_mux_ff_chk #(
  parameter logic [3:0] MAX_CNT = 4'd4
) (
  input logic          clk,
  input logic          rst_n,
  input logic [1:0]    dlc_state,
  input logic          dllp_valid,
  input logic          dllp_ready,
  input logic          tlp_valid,
  input logic          tlp_ready,
  input logic          tx_valid,
  input logic          tx_ready,
  input logic [1195:0] tx_data,
  input logic [3:0]    starv_cnt
);
  a_dllp_ready_needs_valid: assert property (
    @(posedge clk) disable iff (!rst_n) dllp_ready |-> dllp_valid);

  a_tlp_ready_needs_valid_active: assert property (
    @(posedge clk) disable iff (!rst_n) tlp_ready |-> (tlp_valid && (dlc_state == 2'b11)));

  a_single_grant: assert property (
    @(posedge clk) disable iff (!rst_n) !(dllp_ready && tlp_ready));

  a_hold_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (tx_valid && !tx_ready && (dlc_state != 2'b00)) |=> (tx_valid && $stable(tx_data)));

  a_counter_bounded: assert property (
    @(posedge clk) disable iff (!rst_n) starv_cnt <= MAX_CNT);
endmodule

module dll_tx_packet_mux_ff #(
  parameter int unsigned MAX_DLLP_BURST = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  dll_tx_packet_mux_ff_if.slave bus
);
  localparam int unsigned DATA_W = 1196;
  localparam int unsigned DLLP_W = 48;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DLLP_BURST);

  typedef enum logic [1:0] {
    DL_INACTIVE = 2'b00,
    DL_INIT1    = 2'b01,
    DL_INIT2    = 2'b10,
    DL_ACTIVE   = 2'b11
  } dlc_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_DLLP = 2'b01,
    GNT_TLP  = 2'b10,
    GNT_DROP = 2'b11
  } grant_e;

  function automatic logic [DATA_W-1:0] encode_dllp(input logic [DLLP_W-1:0] dllp);
    encode_dllp = {{(DATA_W-DLLP_W){1'b0}}, dllp};
  endfunction

  // The RX demux classifies an all-zero upper field as a DLLP, so such a TLP is unsendable.
  function automatic logic tlp_malformed(input logic [DATA_W-1:0] tlp);
    tlp_malformed = (tlp[DATA_W-1:DLLP_W] == {(DATA_W-DLLP_W){1'b0}});
  endfunction

  dlc_state_e        dlc_state_s;
  grant_e            grant_s;
  grant_e            tlp_kind_s;
  logic              load_en_s;
  logic              burst_hit_s;
  logic              dllp_ready_s;
  logic              tlp_ready_s;

  logic [DATA_W-1:0] tx_data_q;
  logic [DATA_W-1:0] tx_data_d;
  logic              tx_valid_q;
  logic              tx_valid_d;
  logic              tlp_err_q;
  logic              tlp_err_d;
  logic [CNT_W-1:0]  starv_cnt_q;
  logic [CNT_W-1:0]  starv_cnt_d;

  assign dlc_state_s = dlc_state_e'(bus.dlc_state_i);
  assign load_en_s   = !tx_valid_q || bus.tx_ready_i;
  assign burst_hit_s = (starv_cnt_q == MAX_CNT);
  assign tlp_kind_s  = tlp_malformed(bus.tlp_i) ? GNT_DROP : GNT_TLP;

  // Arbitration: DLLP wins unless a waiting TLP has been passed over MAX_DLLP_BURST times.
  always_comb begin
    grant_s = GNT_NONE;
    if (load_en_s) begin
      case (dlc_state_s)
        DL_INIT1, DL_INIT2: begin
          if (bus.dllp_valid_i) begin
            grant_s = GNT_DLLP;
          end else begin
            grant_s = GNT_NONE;
          end
        end
        DL_ACTIVE: begin
          if (bus.dllp_valid_i && bus.tlp_valid_i) begin
            grant_s = burst_hit_s ? tlp_kind_s : GNT_DLLP;
          end else if (bus.dllp_valid_i) begin
            grant_s = GNT_DLLP;
          end else if (bus.tlp_valid_i) begin
            grant_s = tlp_kind_s;
          end else begin
            grant_s = GNT_NONE;
          end
        end
        default: grant_s = GNT_NONE;
      endcase
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // Source readies follow the grant and are forced low while reset is asserted.
  always_comb begin
    dllp_ready_s = 1'b0;
    tlp_ready_s  = 1'b0;
    if (rst_n) begin
      dllp_ready_s = (grant_s == GNT_DLLP);
      tlp_ready_s  = (grant_s == GNT_TLP) || (grant_s == GNT_DROP);
    end else begin
      dllp_ready_s = 1'b0;
      tlp_ready_s  = 1'b0;
    end
  end

  // Output stage and starvation counter next state.
  always_comb begin
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    tlp_err_d   = 1'b0;
    starv_cnt_d = starv_cnt_q;
    if (dlc_state_s == DL_INACTIVE) begin
      tx_data_d   = {DATA_W{1'b0}};
      tx_valid_d  = 1'b0;
      starv_cnt_d = {CNT_W{1'b0}};
    end else begin
      case (grant_s)
        GNT_DLLP: begin
          tx_data_d  = encode_dllp(bus.dllp_i);
          tx_valid_d = 1'b1;
        end
        GNT_TLP: begin
          tx_data_d  = bus.tlp_i;
          tx_valid_d = 1'b1;
        end
        GNT_DROP, GNT_NONE: begin
          if (bus.tx_ready_i) begin
            tx_valid_d = 1'b0;
          end else begin
            tx_valid_d = tx_valid_q;
          end
        end
        default: tx_valid_d = tx_valid_q;
      endcase
      tlp_err_d = (grant_s == GNT_DROP);
      if ((grant_s == GNT_TLP) || (grant_s == GNT_DROP) || !bus.tlp_valid_i) begin
        starv_cnt_d = {CNT_W{1'b0}};
      end else if ((grant_s == GNT_DLLP) && (starv_cnt_q < MAX_CNT)) begin
        starv_cnt_d = starv_cnt_q + 4'd1;
      end else begin
        starv_cnt_d = starv_cnt_q;
      end
    end
  end

  // State registers with asynchronous discard on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q   <= {DATA_W{1'b0}};
      tx_valid_q  <= 1'b0;
      tlp_err_q   <= 1'b0;
      starv_cnt_q <= {CNT_W{1'b0}};
    end else begin
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tlp_err_q   <= tlp_err_d;
      starv_cnt_q <= starv_cnt_d;
    end
  end

  assign bus.dllp_ready_o = dllp_ready_s;
  assign bus.tlp_ready_o  = tlp_ready_s;
  assign bus.tx_data_o    = tx_data_q;
  assign bus.tx_valid_o   = tx_valid_q;
  assign bus.tlp_err_o    = tlp_err_q;

  dll_tx_packet_mux_ff_chk #(
    .MAX_CNT(MAX_CNT)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .dlc_state  (bus.dlc_state_i),
    .dllp_valid (bus.dllp_valid_i),
    .dllp_ready (dllp_ready_s),
    .tlp_valid  (bus.tlp_valid_i),
    .tlp_ready  (tlp_ready_s),
    .tx_valid   (tx_valid_q),
    .tx_ready   (bus.tx_ready_i),
    .tx_data    (tx_data_q),
    .starv_cnt  (starv_cnt_q)
  );
endmodule

// File: doc/dll_tx_packet_mux_ff.md
Name: dll_tx_packet_mux_ff

Overview:
- Transmit-side counterpart of the DLL RX demux. Merges DLLPs (for example InitFC1/InitFC2/UpdateFC) and TLPs onto the single 1196-bit link-side TX stream.
- Encodes DLLPs in the form the RX side decodes: zero-padded, with upper bits [1195:48] all zero.
- Gates traffic by DLC state and arbitrates DLLP-over-TLP with an anti-starvation limit.
- Drives the link through one registered output stage with valid/ready backpressure.

Parameters:
- MAX_DLLP_BURST, 4: consecutive DLLP grants allowed while a TLP is waiting before the TLP is forced through (range 1..15).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- dlc_state_i  input  2  DLC state: 00 DL_INACTIVE, 01 DL_INIT1, 10 DL_INIT2, 11 DL_ACTIVE
- dllp_i  input  48  DLLP payload
- dllp_valid_i  input  1  DLLP offered
- dllp_ready_o  output  1  DLLP accepted this cycle
- tlp_i  input  1196  TLP payload
- tlp_valid_i  input  1  TLP offered
- tlp_ready_o  output  1  TLP consumed this cycle (accepted or dropped)
- tx_data_o  output  1196  registered link data
- tx_valid_o  output  1  tx_data_o valid
- tx_ready_i  input  1  link accepts tx_data_o
- tlp_err_o  output  1  one-cycle pulse: malformed TLP dropped

Behaviour:
- Reset: tx_data_o=0, tx_valid_o=0, tlp_err_o=0, starvation counter=0. dllp_ready_o and tlp_ready_o are 0 while rst_n is low.
- Slot free: load_en = !tx_valid_o || tx_ready_i.
- Hold rule: while tx_valid_o=1 and tx_ready_i=0, tx_data_o is held stable.
- Handshake: transfer on dllp_valid_i&&dllp_ready_o (resp. tlp). Ready outputs are combinational from state, valids, load_en and counter. A ready never asserts without the matching valid.
- State gating:
  - 00: no grants. tx_valid_o clears on the next edge (flush, held data discarded) and the counter clears.
  - 01/10: DLLP only; tlp_ready_o=0.
  - 11: DLLP and TLP both eligible.
- Arbitration in 11, evaluated only when load_en=1:
  - Only one valid: grant it.
  - Both valid: grant DLLP unless starv_cnt==MAX_DLLP_BURST, in which case grant TLP.
- Counter update:
  - starv_cnt +1 on each DLLP grant while tlp_valid_i=1 (saturating at MAX_DLLP_BURST).
  - Cleared on any TLP consume, or when tlp_valid_i=0.
- Latency: granted item appears on tx_data_o/tx_valid_o on the next rising edge, one cycle.
- DLLP encoding: tx_data_o = {1148'b0, dllp_i}.
- TLP encoding: tx_data_o = tlp_i unmodified.
- Malformed TLP: a granted TLP with tlp_i[1195:48]==0 is consumed (tlp_ready_o=1) but not loaded, since the RX demux would misclassify it as a DLLP.
  - Output register is unchanged that cycle, except it clears if tx_ready_i=1.
  - tlp_err_o=1 for exactly one cycle after the consume.
  - starv_cnt clears.
  - No DLLP is granted in the same cycle.
- State change: a TLP already held in the output register when the state leaves 11 for 01/10 is still delivered. Only state 00 flushes.
- Simultaneous events: when tx_ready_i=1 and a new grant occur in the same cycle, the new item replaces the sent item with no bubble. Full throughput is 1 item/cycle.
- Reset mid-transfer: asynchronously discards held data and clears all state.

Test Plan:
- Reset, then state 01, dllp_i=48'h0000_0000_0060 valid, tx_ready_i=1 -> dllp_ready_o=1; next cycle tx_data_o={1148'b0,48'h60}, tx_valid_o=1; tlp_valid_i=1 in same window gives tlp_ready_o=0.
- State 11, tx_ready_i=0 with a DLLP loaded, new DLLP offered -> dllp_ready_o=0 and tx_data_o stable for 3 cycles; raise tx_ready_i -> the new DLLP loads on the next edge.
- State 11, DLLP and TLP valid continuously, tx_ready_i=1, MAX_DLLP_BURST=4 -> output order D,D,D,D,T,D,D,D,D,T.
- State 11, tlp_i with only bits [47:0] nonzero -> tlp_ready_o=1, tx_valid_o stays 0, tlp_err_o high exactly one cycle; next legal TLP passes unchanged.
- Output held (tx_ready_i=0) with a TLP, state goes 11->00 -> tx_valid_o=0 next edge and no grants while in 00; separately, asserting rst_n=0 mid-hold clears tx_valid_o immediately.
